// File: rtl/systolic_input_skewer_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_input_skewer_if
// Brief    : Load/control/operand bus between a tile feeder and its host.
// Revision : 1.0
// ============================================================================
interface systolic_input_skewer_if #(
    parameter int M  = 4,
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = 16
);
    logic            load_valid;
    logic            load_ready;
    logic            load_sel;
    logic [DW-1:0]   load_data;
    logic            start;
    logic            busy;
    logic            done;
    logic            clear_acc;
    logic [M*DW-1:0] a_out;
    logic [M-1:0]    a_valid;
    logic [N*DW-1:0] b_out;
    logic [N-1:0]    b_valid;

    modport master (
        output load_valid, load_sel, load_data, start,
        input  load_ready, busy, done, clear_acc, a_out, a_valid, b_out, b_valid
    );

    modport slave (
        input  load_valid, load_sel, load_data, start,
        output load_ready, busy, done, clear_acc, a_out, a_valid, b_out, b_valid
    );
endinterface
`default_nettype wire

// File: rtl/systolic_input_skewer.sv
`default_nettype none
// ============================================================================
// Module   : systolic_input_skewer
// Brief    : Buffers A (MxK) and B (KxN) tiles, streams skewed wavefronts.
// Revision : 1.0
// ============================================================================
module systolic_input_skewer #(
    parameter int M  = 4,
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    systolic_input_skewer_if.slave bus
);
    localparam int c_S    = K + ((M > N) ? M : N) - 1;
    localparam int c_D    = M + N - 1;
    localparam int c_TMAX = (c_S > c_D) ? c_S : c_D;
    localparam int c_TW   = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;
    localparam int c_AN   = M * K;
    localparam int c_BN   = K * N;
    localparam int c_AW   = (c_AN > 1) ? $clog2(c_AN) : 1;
    localparam int c_BW   = (c_BN > 1) ? $clog2(c_BN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t            r_state, w_state_next;
    logic [c_TW-1:0]   r_t, w_t_next;
    logic [c_AW-1:0]   r_a_cnt;
    logic [c_BW-1:0]   r_b_cnt;
    logic              r_a_full, r_b_full;
    logic [DW-1:0]     r_a_mem [c_AN];
    logic [DW-1:0]     r_b_mem [c_BN];

    logic              w_load_ready, w_a_wr, w_b_wr, w_pass_end;
    logic [M*DW-1:0]   w_a_out, r_a_out;
    logic [M-1:0]      w_a_valid, r_a_valid;
    logic [N*DW-1:0]   w_b_out, r_b_out;
    logic [N-1:0]      w_b_valid, r_b_valid;
    logic              r_busy, r_done, r_clear_acc;
    logic              w_streaming;
    int                w_tn;

    assign w_load_ready = (r_state == ST_IDLE) && !(bus.load_sel ? r_b_full : r_a_full);
    assign w_a_wr       = bus.load_valid && w_load_ready && !bus.load_sel;
    assign w_b_wr       = bus.load_valid && w_load_ready &&  bus.load_sel;
    assign w_pass_end   = (r_state == ST_DRAIN) && (r_t == c_TW'(c_D - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_cnt  <= '0;
            r_b_cnt  <= '0;
            r_a_full <= 1'b0;
            r_b_full <= 1'b0;
        end else if (w_pass_end) begin
            r_a_cnt  <= '0;
            r_b_cnt  <= '0;
            r_a_full <= 1'b0;
            r_b_full <= 1'b0;
        end else begin
            if (w_a_wr) begin
                if (r_a_cnt == c_AW'(c_AN - 1)) begin
                    r_a_full <= 1'b1;
                    r_a_cnt  <= '0;
                end else begin
                    r_a_cnt  <= r_a_cnt + c_AW'(1);
                end
            end
            if (w_b_wr) begin
                if (r_b_cnt == c_BW'(c_BN - 1)) begin
                    r_b_full <= 1'b1;
                    r_b_cnt  <= '0;
                end else begin
                    r_b_cnt  <= r_b_cnt + c_BW'(1);
                end
            end
        end
    end

    // Tile storage carries no reset: contents are only read after a full load.
    always_ff @(posedge clk) begin
        if (w_a_wr) r_a_mem[r_a_cnt] <= bus.load_data;
        if (w_b_wr) r_b_mem[r_b_cnt] <= bus.load_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_t     <= '0;
        end else begin
            r_state <= w_state_next;
            r_t     <= w_t_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_t_next     = r_t;
        case (r_state)
            ST_IDLE: begin
                w_t_next = '0;
                if (bus.start && r_a_full && r_b_full) w_state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (r_t == c_TW'(c_S - 1)) begin
                    w_state_next = ST_DRAIN;
                    w_t_next     = '0;
                end else begin
                    w_t_next     = r_t + c_TW'(1);
                end
            end
            ST_DRAIN: begin
                if (w_pass_end) begin
                    w_state_next = ST_IDLE;
                    w_t_next     = '0;
                end else begin
                    w_t_next     = r_t + c_TW'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_t_next     = '0;
            end
        endcase
    end

    // Operand lanes are computed for the upcoming cycle so they land registered.
    assign w_streaming = (w_state_next == ST_STREAM);
    assign w_tn        = int'(w_t_next);

    for (genvar i = 0; i < M; i++) begin : g_row
        logic            w_v;
        logic [c_AW-1:0] w_idx;
        assign w_v                   = w_streaming && (w_tn >= i) && (w_tn < i + K);
        assign w_idx                 = c_AW'(i * K + w_tn - i);
        assign w_a_valid[i]          = w_v;
        assign w_a_out[i*DW +: DW]   = w_v ? r_a_mem[w_idx] : '0;
    end

    for (genvar j = 0; j < N; j++) begin : g_col
        logic            w_v;
        logic [c_BW-1:0] w_idx;
        assign w_v                   = w_streaming && (w_tn >= j) && (w_tn < j + K);
        assign w_idx                 = c_BW'((w_tn - j) * N + j);
        assign w_b_valid[j]          = w_v;
        assign w_b_out[j*DW +: DW]   = w_v ? r_b_mem[w_idx] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_out     <= '0;
            r_a_valid   <= '0;
            r_b_out     <= '0;
            r_b_valid   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_clear_acc <= 1'b0;
        end else begin
            r_a_out     <= w_a_out;
            r_a_valid   <= w_a_valid;
            r_b_out     <= w_b_out;
            r_b_valid   <= w_b_valid;
            r_busy      <= (w_state_next != ST_IDLE);
            r_done      <= (w_state_next == ST_DRAIN) && (w_t_next == c_TW'(c_D - 1));
            r_clear_acc <= (r_state == ST_IDLE) && (w_state_next == ST_STREAM);
        end
    end

    assign bus.load_ready = w_load_ready;
    assign bus.a_out      = r_a_out;
    assign bus.a_valid    = r_a_valid;
    assign bus.b_out      = r_b_out;
    assign bus.b_valid    = r_b_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.clear_acc  = r_clear_acc;
endmodule
`default_nettype wire
